// File: rtl/tpu_ctrl_pkg.sv
// Shared definitions for the TPU control blocks: controller states and
// width/slice helpers derived from the array dimension.
package tpu_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // Width of the step counter t and of the job length L (L can reach 2*W-1).
    function automatic int cnt_width(input int width_height);
        return $clog2(2 * width_height);
    endfunction

    // Width of row_count / col_count, which must hold 0..W inclusive.
    function automatic int job_width(input int width_height);
        return $clog2(width_height) + 1;
    endfunction

    // LSB of bank j inside the flattened address bus.
    function automatic int bank_lsb(input int j, input int addr_width);
        return j * addr_width;
    endfunction

endpackage

// File: rtl/staggered_mem_ctrl_if.sv
// Sequencer-facing job/handshake bundle for staggered_mem_ctrl.
// master = sequencer side, slave = controller side.
interface staggered_mem_ctrl_if #(
    parameter int ADDR_WIDTH   = 8,
    parameter int WIDTH_HEIGHT = 16,
    parameter int STRIDE_WIDTH = 4
) ();
    localparam int JW = $clog2(WIDTH_HEIGHT) + 1;

    logic                               start;
    logic                               skew_en;
    logic [ADDR_WIDTH-1:0]              base_addr;
    logic [STRIDE_WIDTH-1:0]            stride;
    logic [JW-1:0]                      row_count;
    logic [JW-1:0]                      col_count;
    logic                               busy;
    logic                               done;
    logic [WIDTH_HEIGHT-1:0]            out_en;
    logic [ADDR_WIDTH*WIDTH_HEIGHT-1:0] out_addr;

    modport master (
        output start, skew_en, base_addr, stride, row_count, col_count,
        input  busy, done, out_en, out_addr
    );

    modport slave (
        input  start, skew_en, base_addr, stride, row_count, col_count,
        output busy, done, out_en, out_addr
    );
endinterface

// File: rtl/mem_addr_lane.sv
// One bank's enable/address generator: window compare on the shared step
// counter plus a running address accumulator (no multiplier).
module mem_addr_lane
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int STRIDE_WIDTH = 4,
    parameter int WIDTH_HEIGHT = 16,
    parameter int LANE         = 0,
    parameter int CNT_WIDTH    = cnt_width(WIDTH_HEIGHT),
    parameter int JW           = job_width(WIDTH_HEIGHT)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    launch_i,
    input  logic                    run_i,
    input  logic [CNT_WIDTH-1:0]    t_i,
    input  logic                    skew_i,
    input  logic [JW-1:0]           rows_i,
    input  logic [JW-1:0]           cols_i,
    input  logic [ADDR_WIDTH-1:0]   base_i,
    input  logic [STRIDE_WIDTH-1:0] stride_i,
    output logic                    en_o,
    output logic [ADDR_WIDTH-1:0]   addr_o
);
    // One extra bit so lag + rows never overflows the compare.
    localparam int EW = CNT_WIDTH + 1;

    logic [EW-1:0]         lag;
    logic [EW-1:0]         t_ext;
    logic                  en_d;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] nxt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  en_q;

    always_comb begin
        lag      = skew_i ? EW'(LANE) : '0;
        t_ext    = EW'(t_i);
        en_d     = run_i
                 && (EW'(LANE) < EW'(cols_i))
                 && (t_ext >= lag)
                 && (t_ext < lag + EW'(rows_i));
        // On launch the accumulator still holds the previous job's value.
        cur_addr = launch_i ? base_i : nxt_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            nxt_q  <= '0;
            addr_q <= '0;
            en_q   <= 1'b0;
        end else begin
            en_q   <= en_d;
            addr_q <= en_d ? cur_addr : '0;
            if (en_d) begin
                nxt_q <= cur_addr + ADDR_WIDTH'(stride_i);
            end else if (launch_i) begin
                nxt_q <= base_i;
            end
        end
    end

    assign en_o   = en_q;
    assign addr_o = addr_q;
endmodule

// File: rtl/staggered_mem_ctrl.sv
// Banked operand-memory address/enable generator: uniform or diagonally
// skewed streaming of row_count rows across col_count banks.
module staggered_mem_ctrl
    import tpu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int WIDTH_HEIGHT = 16,
    parameter int STRIDE_WIDTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    staggered_mem_ctrl_if.slave bus
);
    localparam int CNT_WIDTH = cnt_width(WIDTH_HEIGHT);
    localparam int JW        = job_width(WIDTH_HEIGHT);

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    t_q, t_d;
    logic                    skew_q, skew_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [STRIDE_WIDTH-1:0] stride_q, stride_d;
    logic [JW-1:0]           rows_q, rows_d;
    logic [JW-1:0]           cols_q, cols_d;
    logic                    launch;
    logic                    run_d;
    logic [CNT_WIDTH-1:0]    len_q;
    logic [CNT_WIDTH-1:0]    last_t;
    logic                    busy_q, done_q;

    logic [WIDTH_HEIGHT-1:0]            out_en_w;
    logic [ADDR_WIDTH*WIDTH_HEIGHT-1:0] out_addr_w;

    always_comb begin
        launch   = (state_q == IDLE) && bus.start;
        skew_d   = launch ? bus.skew_en   : skew_q;
        base_d   = launch ? bus.base_addr : base_q;
        stride_d = launch ? bus.stride    : stride_q;
        rows_d   = launch ? bus.row_count : rows_q;
        cols_d   = launch ? bus.col_count : cols_q;

        len_q    = skew_q ? CNT_WIDTH'(rows_q) + CNT_WIDTH'(cols_q) - CNT_WIDTH'(1)
                          : CNT_WIDTH'(rows_q);
        last_t   = len_q - CNT_WIDTH'(1);

        state_d  = state_q;
        t_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = ((rows_d == '0) || (cols_d == '0)) ? FIN : RUN;
                end
            end
            RUN: begin
                if (t_q == last_t) begin
                    state_d = FIN;
                end else begin
                    t_d = t_q + CNT_WIDTH'(1);
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        run_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            t_q      <= '0;
            skew_q   <= 1'b0;
            base_q   <= '0;
            stride_q <= '0;
            rows_q   <= '0;
            cols_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            skew_q   <= skew_d;
            base_q   <= base_d;
            stride_q <= stride_d;
            rows_q   <= rows_d;
            cols_q   <= cols_d;
            busy_q   <= run_d;
            done_q   <= (state_d == FIN);
        end
    end

    // Lanes see the next-state view so their flops line up with busy/done.
    generate
        for (genvar gi = 0; gi < WIDTH_HEIGHT; gi++) begin : g_lane
            mem_addr_lane #(
                .ADDR_WIDTH  (ADDR_WIDTH),
                .STRIDE_WIDTH(STRIDE_WIDTH),
                .WIDTH_HEIGHT(WIDTH_HEIGHT),
                .LANE        (gi),
                .CNT_WIDTH   (CNT_WIDTH),
                .JW          (JW)
            ) u_lane (
                .clk     (clk),
                .reset   (reset),
                .launch_i(launch),
                .run_i   (run_d),
                .t_i     (t_d),
                .skew_i  (skew_d),
                .rows_i  (rows_d),
                .cols_i  (cols_d),
                .base_i  (base_d),
                .stride_i(stride_d),
                .en_o    (out_en_w[gi]),
                .addr_o  (out_addr_w[bank_lsb(gi, ADDR_WIDTH) +: ADDR_WIDTH])
            );
        end
    endgenerate

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.out_en   = out_en_w;
    assign bus.out_addr = out_addr_w;
endmodule

// File: tb/tb_staggered_mem_ctrl.sv
// Directed, table-driven bench for staggered_mem_ctrl with hand-computed
// per-cycle expectations and a hand-written mid-job reset sequence.
module tb_staggered_mem_ctrl;

    logic clk;
    logic reset;

    staggered_mem_ctrl_if #(.ADDR_WIDTH(8), .WIDTH_HEIGHT(16), .STRIDE_WIDTH(4)) bus ();

    staggered_mem_ctrl #(.ADDR_WIDTH(8), .WIDTH_HEIGHT(16), .STRIDE_WIDTH(4)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         start;
        logic         skew;
        logic [7:0]   base;
        logic [3:0]   stride;
        logic [4:0]   rows;
        logic [4:0]   cols;
        logic         exp_busy;
        logic         exp_done;
        logic [15:0]  exp_en;
        logic [127:0] exp_addr;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk_vec(input logic st, input logic sk, input logic [7:0] b,
                                    input logic [3:0] s, input logic [4:0] r, input logic [4:0] c,
                                    input logic eb, input logic ed, input logic [15:0] een,
                                    input logic [127:0] ea);
        vec_t v;
        v.start = st; v.skew = sk; v.base = b; v.stride = s; v.rows = r; v.cols = c;
        v.exp_busy = eb; v.exp_done = ed; v.exp_en = een; v.exp_addr = ea;
        return v;
    endfunction

    // Banks 0..n-1 hold address a, the rest 0.
    function automatic logic [127:0] rep(input logic [7:0] a, input int n);
        logic [127:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < n) r[j*8 +: 8] = a;
        end
        return r;
    endfunction

    function automatic logic [127:0] mk3(input logic [7:0] a0, input logic [7:0] a1,
                                         input logic [7:0] a2);
        logic [127:0] r;
        r = '0;
        r[7:0]   = a0;
        r[15:8]  = a1;
        r[23:16] = a2;
        return r;
    endfunction

    task automatic drive(input logic st, input logic sk, input logic [7:0] b,
                         input logic [3:0] s, input logic [4:0] r, input logic [4:0] c);
        bus.start     = st;
        bus.skew_en   = sk;
        bus.base_addr = b;
        bus.stride    = s;
        bus.row_count = r;
        bus.col_count = c;
    endtask

    task automatic check(input string nm, input logic eb, input logic ed,
                         input logic [15:0] een, input logic [127:0] ea);
        n_vec++;
        $display("vec %0d %s busy=%0b done=%0b en=%h addr=%h",
                 n_vec, nm, bus.busy, bus.done, bus.out_en, bus.out_addr);
        if (bus.busy !== eb || bus.done !== ed || bus.out_en !== een || bus.out_addr !== ea) begin
            n_err++;
            $display("FAIL %s: got busy=%0b done=%0b en=%h addr=%h, want busy=%0b done=%0b en=%h addr=%h",
                     nm, bus.busy, bus.done, bus.out_en, bus.out_addr, eb, ed, een, ea);
        end
    endtask

    task automatic step_check(input string nm, input logic eb, input logic ed,
                              input logic [15:0] een, input logic [127:0] ea);
        @(posedge clk);
        #1;
        check(nm, eb, ed, een, ea);
    endtask

    initial begin
        // Uniform job, then a start in its FIN cycle (ignored), then a skewed job
        // launched in the IDLE cycle straight after done.
        vecs.push_back(mk_vec(1, 0, 8'h10, 4'd1, 5'd4, 5'd16, 1, 0, 16'hFFFF, rep(8'h10, 16)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'hFFFF, rep(8'h11, 16)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'hFFFF, rep(8'h12, 16)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'hFFFF, rep(8'h13, 16)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  0, 1, 16'h0000, '0));
        vecs.push_back(mk_vec(1, 1, 8'h00, 4'd2, 5'd3, 5'd3,  0, 0, 16'h0000, '0));
        // Skewed job; start re-pulsed with a different job in cycle 2 is ignored.
        vecs.push_back(mk_vec(1, 1, 8'h00, 4'd2, 5'd3, 5'd3,  1, 0, 16'h0001, mk3(8'h00, 8'h00, 8'h00)));
        vecs.push_back(mk_vec(1, 0, 8'h55, 4'd7, 5'd1, 5'd16, 1, 0, 16'h0003, mk3(8'h02, 8'h00, 8'h00)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'h0007, mk3(8'h04, 8'h02, 8'h00)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'h0006, mk3(8'h00, 8'h04, 8'h02)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'h0004, mk3(8'h00, 8'h00, 8'h04)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  0, 1, 16'h0000, '0));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  0, 0, 16'h0000, '0));
        // Address wrap on two active banks; banks 2..15 stay off.
        vecs.push_back(mk_vec(1, 0, 8'hFE, 4'd1, 5'd4, 5'd2,  1, 0, 16'h0003, rep(8'hFE, 2)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'h0003, rep(8'hFF, 2)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'h0003, rep(8'h00, 2)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  1, 0, 16'h0003, rep(8'h01, 2)));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  0, 1, 16'h0000, '0));
        vecs.push_back(mk_vec(1, 0, 8'h30, 4'd1, 5'd4, 5'd2,  0, 0, 16'h0000, '0));
        // Zero jobs: rows=0, then cols=0; done still pulses, no enables.
        vecs.push_back(mk_vec(1, 0, 8'h30, 4'd1, 5'd0, 5'd16, 0, 1, 16'h0000, '0));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  0, 0, 16'h0000, '0));
        vecs.push_back(mk_vec(1, 1, 8'h30, 4'd1, 5'd3, 5'd0,  0, 1, 16'h0000, '0));
        vecs.push_back(mk_vec(0, 0, 8'h00, 4'd0, 5'd0, 5'd0,  0, 0, 16'h0000, '0));

        reset = 1'b1;
        drive(0, 0, 8'h00, 4'd0, 5'd0, 5'd0);
        step_check("reset", 0, 0, 16'h0000, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].start, vecs[i].skew, vecs[i].base, vecs[i].stride,
                  vecs[i].rows, vecs[i].cols);
            step_check($sformatf("tbl%0d", i), vecs[i].exp_busy, vecs[i].exp_done,
                       vecs[i].exp_en, vecs[i].exp_addr);
        end

        // Reset during cycle 2 of an 8-row job: everything clears, no done follows.
        drive(1, 0, 8'h20, 4'd3, 5'd8, 5'd4);
        step_check("rst_job_c1", 1, 0, 16'h000F, rep(8'h20, 4));
        drive(0, 0, 8'h00, 4'd0, 5'd0, 5'd0);
        step_check("rst_job_c2", 1, 0, 16'h000F, rep(8'h23, 4));
        reset = 1'b1;
        step_check("mid_reset", 0, 0, 16'h0000, '0);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step_check($sformatf("no_done%0d", k), 0, 0, 16'h0000, '0);
        end

        // Fresh job after the abort.
        drive(1, 0, 8'h40, 4'd5, 5'd2, 5'd1);
        step_check("fresh_c1", 1, 0, 16'h0001, rep(8'h40, 1));
        drive(0, 0, 8'h00, 4'd0, 5'd0, 5'd0);
        step_check("fresh_c2", 1, 0, 16'h0001, rep(8'h45, 1));
        step_check("fresh_done", 0, 1, 16'h0000, '0);
        step_check("fresh_idle", 0, 0, 16'h0000, '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/staggered_mem_ctrl.md
# staggered_mem_ctrl

Parametrised address and enable generator for the systolic array's banked operand memories. A single start pulse launches a job of `row_count` rows across `col_count` banks. It runs in one of two modes: uniform, where every bank reads the same address each cycle, or skewed, where bank j lags bank j-1 by one cycle to produce the diagonal wavefront the array expects. The block runs a start/busy/done handshake with the top-level sequencer and supports per-job base address and stride.

## Interface
- `ADDR_WIDTH`, 8, per-bank address width
- `WIDTH_HEIGHT`, 16, number of banks (array dimension), ≥2
- `STRIDE_WIDTH`, 4, width of the per-row address increment
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high
- `start`  in  1  job launch; sampled only in IDLE
- `skew_en`  in  1  0 = uniform, 1 = skewed; latched at start
- `base_addr`  in  ADDR_WIDTH  first row address; latched at start
- `stride`  in  STRIDE_WIDTH  address increment per row; latched at start
- `row_count`  in  $clog2(WIDTH_HEIGHT)+1  rows to stream, 0..WIDTH_HEIGHT
- `col_count`  in  $clog2(WIDTH_HEIGHT)+1  active banks, 0..WIDTH_HEIGHT; banks ≥ col_count stay disabled
- `busy`  out  1  job in progress
- `done`  out  1  one-cycle completion pulse
- `out_en`  out  WIDTH_HEIGHT  per-bank read enable; bit j = bank j
- `out_addr`  out  ADDR_WIDTH*WIDTH_HEIGHT  per-bank address; bank j in slice [j*ADDR_WIDTH +: ADDR_WIDTH]

## Operation
- States:
  - IDLE: wait for start.
  - RUN: streaming.
  - FIN: emit done; always 1 cycle, then back to IDLE.
- IDLE→RUN when `start` is sampled. The latched job fields are fixed for the whole job; the step counter t is cleared to 0.
- RUN: t increments by 1 each cycle. The job length is:
  - L = row_count in uniform mode;
  - L = row_count + col_count − 1 in skewed mode.
  - RUN→FIN after the cycle where t = L−1.
- Bank j (j < col_count), with lag d = 0 in uniform mode and d = j in skewed mode:
  - enabled when d ≤ t < d + row_count;
  - address = base_addr + (t−d)*stride, modulo 2^ADDR_WIDTH (wraps silently, no error).
- A disabled bank drives `out_en[j]`=0 and address 0.
- Zero job (row_count=0 or col_count=0): IDLE→FIN directly. No enable is ever asserted, but done still pulses.
- `start` while not IDLE is ignored; no queuing.
- `start` in the FIN cycle is ignored. The sequencer re-issues it in IDLE.
- Reset, at any time including mid-job: next cycle state=IDLE, t=0, and every output is 0. The aborted job emits no done.

## Timing
- All outputs are registered. Reset values: busy=0, done=0, out_en=0, out_addr=0.
- `start` sampled at edge E0 (in IDLE) → the first enabled cycle, t=0, is visible after E0. Launch latency is 1 cycle.
- busy is high in every RUN cycle and low in IDLE and FIN.
- done is high for exactly the FIN cycle, which is the cycle after the last RUN cycle.
- Minimum start-to-start spacing is L+2 cycles.

## Structure
- Shared package `tpu_ctrl_pkg` holds:
  - the state enum (IDLE, RUN, FIN);
  - localparam CNT_WIDTH = $clog2(2*WIDTH_HEIGHT), the width of t and of L;
  - the bank-slice helper constants.
- Sub-module `mem_addr_lane`, instantiated WIDTH_HEIGHT times via generate.
  - Each lane holds its own address register: it loads base_addr on launch and adds stride on each cycle it is enabled. This avoids a multiplier per lane.
  - Each lane computes its own window compare from t, its constant lane index, skew_en, row_count and col_count.
- The top level holds the FSM, the t counter, the latched job fields, and the output flops.

## Test plan
- Uniform: base=0x10, stride=1, rows=4, cols=16, skew=0.
  - Banks 0..15 all read 0x10,0x11,0x12,0x13 in cycles 1..4 after start.
  - busy is high for 4 cycles; done pulses in cycle 5.
- Skewed: base=0x00, stride=2, rows=3, cols=3.
  - Bank0 reads 0,2,4 in cycles 1–3; bank1 reads 0,2,4 in cycles 2–4; bank2 reads 0,2,4 in cycles 3–5.
  - Banks 3..15 stay disabled; done pulses in cycle 6.
- Wrap: base=0xFE, stride=1, rows=4, uniform → addresses 0xFE,0xFF,0x00,0x01.
- Ignored start, zero job, and back-to-back:
  - start re-pulsed mid-run → no effect on addresses or length.
  - rows=0 → done pulses in cycle 1 with out_en always 0.
  - a new start in the cycle after done → accepted.
- Reset during cycle 2 of an 8-row job → all outputs are 0 on the next cycle, no done pulse, and a fresh job then runs correctly.
